arc4_decrypt_fsm: RTL and testbench
===================================

Name: arc4_decrypt_fsm

Overview:
- Third stage of the ARC4 chain. It runs after the S-array init FSM and the key-schedule FSM (task2aFSM) have finished writing S memory.
- Reads the permuted S array back out of the same single-port S RAM and runs the PRGA, swapping S entries as it goes.
- XORs each keystream byte with the encrypted-message ROM and writes plaintext into the decrypted-message RAM.
- It is the reader/consumer of the S memory that the key-schedule FSM writes.

Parameters:
- MSG_LEN, 32, number of message bytes to decrypt (1..256).
- MSG_AW, 5, address width of the message ROM and output RAM (2^MSG_AW >= MSG_LEN).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins decryption when idle.
- finish  out  1  single-cycle pulse when the last plaintext byte has been written.
- s_address  out  8  S RAM address.
- s_data  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- s_q  in  8  S RAM read data.
- rom_address  out  MSG_AW  encrypted ROM address.
- rom_q  in  8  encrypted ROM data.
- out_address  out  MSG_AW  decrypted RAM address.
- out_data  out  8  decrypted RAM write data.
- out_wren  out  1  decrypted RAM write enable.

Behaviour:
- Memory timing: all memories use a registered address and an unregistered q. Read data is valid in the cycle after the address is driven.
- Internal registers: i, j, si, sj, f, enc (8b each), k (MSG_AW+1 b).
- Reset: state=IDLE; i=j=k=0; finish=0; s_wren=0; out_wren=0; all addresses and data = 0. Reset in any state aborts at once; no further writes occur.
- IDLE: on start=1, set i=1, j=0, k=0 and go to READ_I. Otherwise stay in IDLE.
- Per-byte sequence, one cycle per state, 9 cycles per byte:
  - READ_I: s_address=i.
  - LOAD_I: si<=s_q; j<=j+s_q (mod 256).
  - READ_J: s_address=j.
  - LOAD_J: sj<=s_q.
  - WRITE_I: s_address=i, s_data=sj, s_wren=1.
  - WRITE_J: s_address=j, s_data=si, s_wren=1.
  - READ_F: s_address=si+sj (8-bit wrap); rom_address=k.
  - LOAD_F: f<=s_q; enc<=rom_q.
  - WRITE_OUT: out_address=k, out_data=f^enc, out_wren=1; k<=k+1; i<=i+1 (mod 256). If k==MSG_LEN-1, go to DONE; else go to READ_I.
- DONE: finish=1 for exactly one cycle, then IDLE.
- Latency: finish is high in cycle 9*MSG_LEN+1 after the edge that samples start.
- Write enables: s_wren is high only in WRITE_I/WRITE_J; out_wren is high only in WRITE_OUT. Both are 0 in every other state.
- start while busy (any state other than IDLE) is ignored.
- i==j: both writes still occur. WRITE_J overwrites with an identical value, so S is unchanged.
- All index arithmetic (i, j, si+sj) is modulo 256. i wraps from 255 to 0 when MSG_LEN=256.

Test Plan:
- S identity (S[x]=x), ROM all 0x00, MSG_LEN=32, pulse start:
  - out[0]=0x02, out[1]=0x05, out[2]=0x07.
  - After byte 1: S[2]=3, S[3]=2. After byte 2: S[3]=5, S[5]=2.
  - finish pulses once at cycle 289.
- Same S, ROM[0]=0xFF -> out[0]=0xFD (XOR path check).
- Wrap: S identity except S[1]=0xFF and S[0xFF]=0x01; ROM[0]=0xA5:
  - j=0xFF, sj=0x01, f address=0x00, out[0]=0xA5.
  - S[1]=0x01 and S[0xFF]=0xFF after the swap.
- i==j: S identity, byte 0 (i=j=1) -> both WRITE_I and WRITE_J write 0x01 to address 1; S[1] stays 0x01.
- Reset asserted in WRITE_J of byte 5:
  - Next cycle all wrens=0, no finish.
  - A new start re-runs from k=0 and finish follows 289 cycles later.
- Second start pulse during byte 3 -> ignored; exactly 32 out writes and one finish.

Source files
------------

// File: rtl/arc4_decrypt_fsm.sv
// ARC4 PRGA stage: walks the key-scheduled S array, swaps entries and
// XORs each keystream byte with the encrypted ROM into the output RAM.
module arc4_decrypt_fsm #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              finish,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [MSG_AW-1:0] rom_address,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] out_address,
    output logic [7:0]        out_data,
    output logic              out_wren
);

    typedef enum logic [3:0] {
        IDLE,
        READ_I,
        LOAD_I,
        READ_J,
        LOAD_J,
        WRITE_I,
        WRITE_J,
        READ_F,
        LOAD_F,
        WRITE_OUT,
        DONE
    } state_t;

    localparam logic [MSG_AW:0] K_LAST = (MSG_AW + 1)'(MSG_LEN - 1);

    state_t          state_q, state_d;
    logic [7:0]      i_q, i_d;
    logic [7:0]      j_q, j_d;
    logic [7:0]      si_q, si_d;
    logic [7:0]      sj_q, sj_d;
    logic [7:0]      f_q, f_d;
    logic [7:0]      enc_q, enc_d;
    logic [MSG_AW:0] k_q, k_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            f_q     <= '0;
            enc_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            enc_q   <= enc_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        si_d        = si_q;
        sj_d        = sj_q;
        f_d         = f_q;
        enc_d       = enc_q;
        k_d         = k_q;
        finish      = 1'b0;
        s_address   = '0;
        s_data      = '0;
        s_wren      = 1'b0;
        rom_address = '0;
        out_address = '0;
        out_data    = '0;
        out_wren    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    i_d     = 8'd1;
                    j_d     = 8'd0;
                    k_d     = '0;
                    state_d = READ_I;
                end
            end
            READ_I: begin
                s_address = i_q;
                state_d   = LOAD_I;
            end
            LOAD_I: begin
                si_d    = s_q;
                j_d     = j_q + s_q;
                state_d = READ_J;
            end
            READ_J: begin
                s_address = j_q;
                state_d   = LOAD_J;
            end
            LOAD_J: begin
                sj_d    = s_q;
                state_d = WRITE_I;
            end
            WRITE_I: begin
                s_address = i_q;
                s_data    = sj_q;
                s_wren    = 1'b1;
                state_d   = WRITE_J;
            end
            WRITE_J: begin
                s_address = j_q;
                s_data    = si_q;
                s_wren    = 1'b1;
                state_d   = READ_F;
            end
            READ_F: begin
                s_address   = si_q + sj_q;
                rom_address = k_q[MSG_AW-1:0];
                state_d     = LOAD_F;
            end
            LOAD_F: begin
                f_d     = s_q;
                enc_d   = rom_q;
                state_d = WRITE_OUT;
            end
            WRITE_OUT: begin
                out_address = k_q[MSG_AW-1:0];
                out_data    = f_q ^ enc_q;
                out_wren    = 1'b1;
                k_d         = k_q + 1'b1;
                i_d         = i_q + 8'd1;
                state_d     = (k_q == K_LAST) ? DONE : READ_I;
            end
            DONE: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_arc4_decrypt_fsm.sv
// Directed bench for arc4_decrypt_fsm with behavioural S RAM, ROM and
// output RAM models (registered address, unregistered q).
module tb_arc4_decrypt_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       finish;
    logic [7:0] s_address, s_data, s_q;
    logic       s_wren;
    logic [4:0] rom_address, out_address;
    logic [7:0] rom_q, out_data;
    logic       out_wren;

    arc4_decrypt_fsm #(.MSG_LEN(32), .MSG_AW(5)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .finish(finish),
        .s_address(s_address),
        .s_data(s_data),
        .s_wren(s_wren),
        .s_q(s_q),
        .rom_address(rom_address),
        .rom_q(rom_q),
        .out_address(out_address),
        .out_data(out_data),
        .out_wren(out_wren)
    );

    always #5 clock = ~clock;

    logic [7:0] s_mem [256];
    logic [7:0] s_init [256];
    logic [7:0] rom [32];
    logic [7:0] out_mem [32];
    logic [7:0] s_addr_r;
    logic [4:0] rom_addr_r;
    logic       ld_s = 1'b0;
    logic       clr = 1'b1;

    always @(posedge clock) begin
        if (ld_s) s_mem <= s_init;
        else if (s_wren) s_mem[s_address] <= s_data;
        s_addr_r   <= s_address;
        rom_addr_r <= rom_address;
    end
    assign s_q   = s_mem[s_addr_r];
    assign rom_q = rom[rom_addr_r];

    int out_cnt, fin_cnt, sw_cnt, nlog;
    logic [7:0] log_a [2];
    logic [7:0] log_d [2];
    logic [7:0] snap1, snapff, snap2, snap3a, snap3b, snap5;

    always @(posedge clock) begin
        if (clr) begin
            out_cnt <= 0;
            fin_cnt <= 0;
            sw_cnt  <= 0;
            nlog    <= 0;
        end else begin
            if (out_wren) begin
                out_mem[out_address] <= out_data;
                out_cnt <= out_cnt + 1;
                sw_cnt  <= 0;
                if (out_address == 5'd0) begin
                    snap1  <= s_mem[1];
                    snapff <= s_mem[255];
                end
                if (out_address == 5'd1) begin
                    snap2  <= s_mem[2];
                    snap3a <= s_mem[3];
                end
                if (out_address == 5'd2) begin
                    snap3b <= s_mem[3];
                    snap5  <= s_mem[5];
                end
            end
            if (s_wren) begin
                sw_cnt <= sw_cnt + 1;
                if (out_cnt == 0 && nlog < 2) begin
                    log_a[nlog] <= s_address;
                    log_d[nlog] <= s_data;
                    nlog <= nlog + 1;
                end
            end
            if (finish) fin_cnt <= fin_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic [7:0] rom0, input bit wrap);
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        if (wrap) begin
            s_init[1]   = 8'hFF;
            s_init[255] = 8'h01;
        end
        for (int x = 0; x < 32; x++) rom[x] = 8'h00;
        rom[0] = rom0;
        reset = 1'b1;
        clr   = 1'b1;
        ld_s  = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        clr   = 1'b0;
        ld_s  = 1'b0;
        @(negedge clock);
    endtask

    task automatic run(output int cyc);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (!finish && cyc < 400) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    int cyc;
    int guard;
    int hold;

    initial begin
        // reset state
        setup(8'h00, 1'b0);
        chk("rst_finish", 32'(finish), 0);
        chk("rst_s_wren", 32'(s_wren), 0);
        chk("rst_out_wren", 32'(out_wren), 0);
        chk("rst_s_addr", 32'(s_address), 0);
        chk("rst_s_data", 32'(s_data), 0);
        chk("rst_rom_addr", 32'(rom_address), 0);
        chk("rst_out_addr", 32'(out_address), 0);
        chk("rst_out_data", 32'(out_data), 0);

        // identity S, zero ROM
        run(cyc);
        chk("a_latency", 32'(cyc), 289);
        @(negedge clock);
        chk("a_finish_one_cycle", 32'(finish), 0);
        chk("a_out0", 32'(out_mem[0]), 32'h02);
        chk("a_out1", 32'(out_mem[1]), 32'h05);
        chk("a_out2", 32'(out_mem[2]), 32'h07);
        chk("a_s2_b1", 32'(snap2), 3);
        chk("a_s3_b1", 32'(snap3a), 2);
        chk("a_s3_b2", 32'(snap3b), 5);
        chk("a_s5_b2", 32'(snap5), 2);
        chk("a_fin_cnt", 32'(fin_cnt), 1);
        chk("a_out_cnt", 32'(out_cnt), 32);
        chk("ieqj_nlog", 32'(nlog), 2);
        chk("ieqj_wi_addr", 32'(log_a[0]), 1);
        chk("ieqj_wi_data", 32'(log_d[0]), 1);
        chk("ieqj_wj_addr", 32'(log_a[1]), 1);
        chk("ieqj_wj_data", 32'(log_d[1]), 1);
        chk("ieqj_s1", 32'(snap1), 1);

        // XOR path
        setup(8'hFF, 1'b0);
        run(cyc);
        chk("b_latency", 32'(cyc), 289);
        chk("b_out0", 32'(out_mem[0]), 32'hFD);

        // modulo-256 wrap
        setup(8'hA5, 1'b1);
        run(cyc);
        chk("w_latency", 32'(cyc), 289);
        chk("w_out0", 32'(out_mem[0]), 32'hA5);
        chk("w_j_addr", 32'(log_a[1]), 32'hFF);
        chk("w_wj_data", 32'(log_d[1]), 32'hFF);
        chk("w_wi_data", 32'(log_d[0]), 32'h01);
        chk("w_s1", 32'(snap1), 32'h01);
        chk("w_sff", 32'(snapff), 32'hFF);

        // reset during WRITE_J of byte 5
        setup(8'h00, 1'b0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        guard = 0;
        while (!(s_wren && out_cnt == 5 && sw_cnt == 1) && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        chk("r_found_wj", 32'(guard < 300), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("r_s_wren", 32'(s_wren), 0);
        chk("r_out_wren", 32'(out_wren), 0);
        chk("r_finish", 32'(finish), 0);
        @(negedge clock);
        reset = 1'b0;
        hold = out_cnt;
        repeat (20) @(negedge clock);
        chk("r_no_out_wr", 32'(out_cnt), 32'(hold));
        chk("r_out_cnt5", 32'(out_cnt), 5);
        chk("r_no_finish", 32'(fin_cnt), 0);
        clr = 1'b1;
        @(negedge clock);
        clr = 1'b0;
        run(cyc);
        chk("r_rerun_latency", 32'(cyc), 289);
        @(negedge clock);
        chk("r_rerun_out_cnt", 32'(out_cnt), 32);
        chk("r_rerun_fin_cnt", 32'(fin_cnt), 1);

        // start while busy
        setup(8'h00, 1'b0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (!finish && cyc < 400) begin
            @(negedge clock);
            cyc++;
            start = (cyc == 30);
        end
        start = 1'b0;
        chk("s_latency", 32'(cyc), 289);
        repeat (20) @(negedge clock);
        chk("s_out_cnt", 32'(out_cnt), 32);
        chk("s_fin_cnt", 32'(fin_cnt), 1);
        chk("s_out2", 32'(out_mem[2]), 32'h07);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
